capture_ctrl: RTL

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/vid_dbg_pkg.sv | 20 ++
 rtl/ram.sv | 34 +++
 rtl/capture_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/vid_dbg_pkg.sv
// Shared definitions for the video debug capture path: FSM encoding and
// default buffer geometry, also used by the register-interface block.
package vid_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int VID_RAM_DEPTH = 1024;
    localparam int VID_AW        = $clog2(VID_RAM_DEPTH);

    // Address width that stays at least one bit for degenerate depths.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port capture buffer: one write port, one registered read port
// whose output register clears on reset and holds when oe is low.
module ram #(
    parameter int DATA_WIDTH = 36,
    parameter int RAM_DEPTH  = 1024,
    parameter int AW         = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  oe,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (oe) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Video capture controller: arm/trigger/stop sequencing of sample storage into
// a capture buffer, with single-cycle readout once the session is done.
module capture_ctrl
    import vid_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int RAM_DEPTH  = VID_RAM_DEPTH,
    localparam int AW        = addr_w(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  trig,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  vid_valid,
    output logic                  busy,
    output logic                  done,
    output logic [AW:0]           count,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(RAM_DEPTH - 1);

    cap_state_t state;
    logic       wr_en;
    logic       rd_hit;
    logic       last_wr;

    // The trigger cycle itself may carry the first sample.
    assign wr_en   = vid_valid && (((state == ST_ARMED) && trig) || (state == ST_CAPTURE));
    assign last_wr = wr_en && (count == LAST_IDX);
    assign rd_hit  = rd_req && (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (wr_en) begin
                count <= count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state <= ST_ARMED;
                        busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        if (last_wr) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // A valid sample coincident with stop is still counted above.
                    if (last_wr || stop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state <= ST_ARMED;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (count[AW-1:0]),
        .wdata (vid_data),
        .oe    (rd_hit),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
